// File: rtl/jstk_pkg.sv
// jstk_pkg: shared types and constants for the PmodJSTK-emulating SPI responder.
//   state_t            responder frame state
//   CMD_LED_PREFIX     upper six bits of a byte-0 LED command
//   LOOPBACK_SEED      first tx byte when JSTK_LOOPBACK_EN is defined
//   DEFAULT_NUM_BYTES  bytes per joystick poll frame
//   joystick_byte()    maps a frame byte index to its joystick payload byte
package jstk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [5:0]  CMD_LED_PREFIX    = 6'b100000;
  localparam logic [7:0]  LOOPBACK_SEED     = 8'hA5;
  localparam int unsigned DEFAULT_NUM_BYTES = 5;

  function automatic logic [7:0] joystick_byte(input logic [7:0] idx,
                                               input logic [9:0] x,
                                               input logic [9:0] y,
                                               input logic [2:0] btn);
    logic [7:0] b;
    case (idx)
      8'd0:    b = x[7:0];
      8'd1:    b = {6'b0, x[9:8]};
      8'd2:    b = y[7:0];
      8'd3:    b = {6'b0, y[9:8]};
      8'd4:    b = {5'b0, btn};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync: multi-flop synchronizer plus registered rise/fall detector
// for one asynchronous SPI pin.
//   clk    system clock
//   rst    synchronous active-high reset (edge register and pulses only)
//   din    asynchronous pin
//   level  synchronized pin level
//   rise   one-cycle pulse after a synchronized 0->1 transition
//   fall   one-cycle pulse after a synchronized 1->0 transition
// The synchronizer chain itself is not reset, so it tracks the pin while
// reset is held; the edge register resets to RESET_VAL.
module spi_input_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign level = chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
      fall <= ~level & prev;
    end
  end

endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave answering a 5-byte PmodJSTK poll.
//   ClkPort     system clock            Reset       sync active-high reset
//   SS/SCLK/MOSI  SPI inputs from master (oversampled on ClkPort)
//   MISO        slave data out, MSB first
//   x_pos/y_pos/buttons  joystick sources, snapshotted at SS fall
//   rx_byte/rx_valid     last complete MOSI byte and its update pulse
//   led_cmd     LED bits from a byte-0 command {100000,led[1:0]}
//   frame_done  pulse when SS rises after a complete frame
//   busy        high while not idle
// Build option JSTK_LOOPBACK_EN: tx byte 0 = 8'hA5, tx byte n = byte n-1
// received; joystick inputs are then unused.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_BYTES   = DEFAULT_NUM_BYTES
) (
  input  logic       ClkPort,
  input  logic       Reset,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [1:0] led_cmd,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [7:0] LAST_BYTE = 8'(NUM_BYTES - 1);

  logic ss_level, ss_rise, ss_fall;
  logic sclk_rise, sclk_fall, unused_sclk_level;
  logic mosi_level, unused_mosi_rise, unused_mosi_fall;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(ClkPort), .rst(Reset), .din(SS),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(ClkPort), .rst(Reset), .din(SCLK),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(ClkPort), .rst(Reset), .din(MOSI),
    .level(mosi_level), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  state_t     state, state_next;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [7:0] rx_sr;
  logic [7:0] rx_next;
  logic [7:0] tx_cur;
  logic [7:0] first_byte;
  logic       armed;
  logic       start;

`ifndef JSTK_LOOPBACK_EN
  logic [9:0] snap_x;
  logic [9:0] snap_y;
  logic [2:0] snap_btn;
`else
  logic unused_inputs;
  assign unused_inputs = ^{x_pos, y_pos, buttons};
`endif

  // SS must be seen high after reset before a fall may open a frame, so SS
  // held low across reset cannot start one.
  assign start   = ss_fall & armed;
  assign rx_next = {rx_sr[6:0], mosi_level};
  assign busy    = (state != IDLE);

  always_comb begin
`ifdef JSTK_LOOPBACK_EN
    first_byte = LOOPBACK_SEED;
    tx_cur     = (byte_cnt == 8'd0) ? LOOPBACK_SEED : rx_byte;
`else
    first_byte = x_pos[7:0];
    tx_cur     = joystick_byte(byte_cnt, snap_x, snap_y, snap_btn);
`endif
  end

  always_ff @(posedge ClkPort) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // SS rise takes priority over any SCLK edge seen in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = SHIFT;
      SHIFT: begin
        if (ss_rise)
          state_next = IDLE;
        else if (sclk_rise && bit_cnt == 3'd7 && byte_cnt == LAST_BYTE)
          state_next = DONE;
      end
      DONE:  if (ss_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      MISO       <= 1'b0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      led_cmd    <= '0;
      frame_done <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_sr      <= '0;
      armed      <= 1'b0;
`ifndef JSTK_LOOPBACK_EN
      snap_x     <= '0;
      snap_y     <= '0;
      snap_btn   <= '0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      if (ss_level) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
`ifndef JSTK_LOOPBACK_EN
            snap_x   <= x_pos;
            snap_y   <= y_pos;
            snap_btn <= buttons;
`endif
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_sr    <= '0;
            MISO     <= first_byte[7];
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            MISO <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr <= rx_next;
            if (bit_cnt == 3'd7) begin
              bit_cnt  <= '0;
              byte_cnt <= byte_cnt + 8'd1;
              rx_byte  <= rx_next;
              rx_valid <= 1'b1;
              if (byte_cnt == 8'd0 && rx_next[7:2] == CMD_LED_PREFIX)
                led_cmd <= rx_next[1:0];
              if (byte_cnt == LAST_BYTE)
                MISO <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else if (sclk_fall) begin
            // bit_cnt == 0 here means a byte just completed and byte_cnt
            // already points at the next tx byte, so its MSB goes out.
            MISO <= tx_cur[3'd7 - bit_cnt];
          end
        end
        DONE: begin
          MISO <= 1'b0;
          if (ss_rise) frame_done <= 1'b1;
        end
        default: MISO <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
module tb_jstk_spi_responder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned NB   = 5;
  localparam int unsigned HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic [9:0] x_pos = 10'h2A5, y_pos = 10'h13C;
  logic [2:0] buttons = 3'b101;
  logic       miso, rx_valid, frame_done, busy;
  logic [7:0] rx_byte;
  logic [1:0] led_cmd;

  jstk_spi_responder #(.SYNC_STAGES(SYNC), .NUM_BYTES(NB)) dut (
    .ClkPort(clk), .Reset(rst), .SS(ss), .SCLK(sclk), .MOSI(mosi), .MISO(miso),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .led_cmd(led_cmd),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned pass_cnt = 0, total_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Model state: bytes the master has fully sent and not yet seen as rx_valid,
  // LED bits implied by byte-0 commands, and pending frame_done pulses.
  typedef struct {logic [7:0] val; bit first;} rx_exp_t;
  rx_exp_t     rx_q[$];
  rx_exp_t     e;
  int          fd_pending = 0;
  logic [1:0]  m_led = 2'b00;
  int unsigned rv_seen = 0, fd_seen = 0, fd_cyc = 0;
  int unsigned rv_cyc[$];

  logic [7:0]  mosi_tx[NB];
  logic [7:0]  miso_got[NB];
  logic [7:0]  miso_exp[NB];
  int unsigned rise8_cyc = 0, ss_rise_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_q.delete();
      m_led = 2'b00;
    end else begin
      if (rx_valid) begin
        rv_seen++;
        rv_cyc.push_back(cyc);
        check("rx_valid_pending", 32'(rx_q.size() > 0), 1);
        if (rx_q.size() > 0) begin
          e = rx_q.pop_front();
          if (e.first && e.val[7:2] == 6'b100000) m_led = e.val[1:0];
          check("rx_byte", 32'(rx_byte), 32'(e.val));
        end
      end
      if (frame_done) begin
        fd_seen++;
        fd_cyc = cyc;
        check("frame_done_pending", 32'(fd_pending > 0), 1);
        if (fd_pending > 0) fd_pending--;
      end
      check("led_cmd", 32'(led_cmd), 32'(m_led));
    end
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master: sends nbits of mosi_tx, samples MISO on each SCLK rise.
  task automatic frame(input int unsigned nbits, input bit raise_ss);
    int unsigned bi, bt;
    ss = 1'b0;
`ifdef JSTK_LOOPBACK_EN
    miso_exp[0] = 8'hA5;
    for (int n = 1; n < NB; n++) miso_exp[n] = mosi_tx[n-1];
`else
    miso_exp[0] = x_pos[7:0];
    miso_exp[1] = {6'b0, x_pos[9:8]};
    miso_exp[2] = y_pos[7:0];
    miso_exp[3] = {6'b0, y_pos[9:8]};
    miso_exp[4] = {5'b0, buttons};
`endif
    for (int n = 0; n < NB; n++) miso_got[n] = 8'h00;
    wait_cyc(HALF);
    for (int unsigned i = 0; i < nbits; i++) begin
      bi = i / 8;
      bt = 7 - (i % 8);
      mosi = mosi_tx[bi][bt];
      wait_cyc(HALF);
      miso_got[bi][bt] = miso;
      sclk = 1'b1;
      if (i % 8 == 7) begin
        rx_q.push_back('{mosi_tx[bi], bi == 0});
        if (i == 7) rise8_cyc = cyc;
      end
      wait_cyc(HALF);
      sclk = 1'b0;
    end
    wait_cyc(HALF);
    if (raise_ss) begin
      ss = 1'b1;
      ss_rise_cyc = cyc;
      if (nbits == 8 * NB) fd_pending++;
      wait_cyc(3 * HALF);
    end
    for (int unsigned n = 0; n < nbits / 8; n++)
      check("miso_byte", 32'(miso_got[n]), 32'(miso_exp[n]));
  endtask

  task automatic set_tx(input logic [7:0] b0, b1, b2, b3, b4);
    mosi_tx[0] = b0; mosi_tx[1] = b1; mosi_tx[2] = b2; mosi_tx[3] = b3; mosi_tx[4] = b4;
  endtask

  task automatic clear_counts();
    rv_seen = 0;
    fd_seen = 0;
    rv_cyc.delete();
  endtask

  initial begin
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);
    check("rst_miso", 32'(miso), 0);
    check("rst_rx_byte", 32'(rx_byte), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_led", 32'(led_cmd), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_busy", 32'(busy), 0);

`ifdef JSTK_LOOPBACK_EN
    set_tx(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    clear_counts();
    frame(40, 1'b1);
    check("lb_b0", 32'(miso_got[0]), 'hA5);
    check("lb_b1", 32'(miso_got[1]), 'h11);
    check("lb_b2", 32'(miso_got[2]), 'h22);
    check("lb_b3", 32'(miso_got[3]), 'h33);
    check("lb_b4", 32'(miso_got[4]), 'h44);
    check("lb_rv_count", rv_seen, 5);
    check("lb_fd_count", fd_seen, 1);
`else
    // Full poll with LED command 0x83.
    set_tx(8'h83, 8'h00, 8'h00, 8'h00, 8'h00);
    clear_counts();
    frame(40, 1'b1);
    check("s1_b0", 32'(miso_got[0]), 'hA5);
    check("s1_b1", 32'(miso_got[1]), 'h02);
    check("s1_b2", 32'(miso_got[2]), 'h3C);
    check("s1_b3", 32'(miso_got[3]), 'h01);
    check("s1_b4", 32'(miso_got[4]), 'h05);
    check("s1_led", 32'(led_cmd), 'h3);
    check("s1_rv_count", rv_seen, 5);
    check("s1_fd_count", fd_seen, 1);
    check("s1_rv_latency", (rv_cyc.size() > 0) ? rv_cyc[0] - rise8_cyc : 0, SYNC + 2);
    check("s1_fd_latency", fd_cyc - ss_rise_cyc, SYNC + 2);

    // Non-command byte 0 leaves LED bits alone.
    set_tx(8'h40, 8'h12, 8'h34, 8'h56, 8'h78);
    clear_counts();
    frame(40, 1'b1);
    check("s2_led", 32'(led_cmd), 'h3);
    check("s2_rv_count", rv_seen, 5);

    // x_pos change mid-frame is invisible until the next frame.
    set_tx(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    fork
      frame(40, 1'b1);
      begin
        @(posedge sclk);
        #1 x_pos = 10'h3FF;
      end
    join
    check("s3a_b0", 32'(miso_got[0]), 'hA5);
    check("s3a_b1", 32'(miso_got[1]), 'h02);
    frame(40, 1'b1);
    check("s3b_b0", 32'(miso_got[0]), 'hFF);
    check("s3b_b1", 32'(miso_got[1]), 'h03);
`endif

    // Abort after 3 bits of byte 2.
    set_tx(8'h81, 8'h5A, 8'hC3, 8'h00, 8'h00);
    clear_counts();
    frame(19, 1'b1);
    check("ab_rv_count", rv_seen, 2);
    check("ab_fd_count", fd_seen, 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_led", 32'(led_cmd), 'h1);
    clear_counts();
    frame(40, 1'b1);
    check("ab_next_rv", rv_seen, 5);
    check("ab_next_fd", fd_seen, 1);

    // Reset mid-byte with SS held low.
    set_tx(8'h83, 8'h00, 8'h00, 8'h00, 8'h00);
    frame(13, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    check("mr_miso", 32'(miso), 0);
    check("mr_rx_byte", 32'(rx_byte), 0);
    check("mr_led", 32'(led_cmd), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_frame_done", 32'(frame_done), 0);
    clear_counts();
    mosi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_cyc(HALF);
      sclk = ~sclk;
    end
    wait_cyc(HALF);
    check("mr_idle_busy", 32'(busy), 0);
    check("mr_idle_rv", rv_seen, 0);
    ss = 1'b1;
    wait_cyc(2 * HALF);
    frame(40, 1'b1);
    check("mr_next_rv", rv_seen, 5);
    check("mr_next_fd", fd_seen, 1);
    check("mr_next_led", 32'(led_cmd), 'h3);

    check("q_drained", 32'(rx_q.size()), 0);
    check("fd_drained", 32'(fd_pending), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
